// File: rtl/rr_arbiter16_if.sv
// rr_arbiter16_if: request/grant bundle for the 16-way arbiter.
// master = requesting side, slave = arbiter.
interface rr_arbiter16_if;
  logic [15:0] req;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic [7:0]  hold_cnt;

  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  hold_cnt
  );

  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output grant_valid,
    output hold_cnt
  );
endinterface

// File: rtl/rr_arbiter16.sv
// rr_arbiter16: registered 16-way round-robin arbiter with
// hold-time preemption; outputs decode the owner registers.
module rr_arbiter16 #(
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter16_if.slave  bus
);

  typedef enum logic {
    S_IDLE,
    S_OWNED
  } state_t;

  localparam logic [7:0] LP_MAX = 8'(MAX_HOLD);

  state_t      r_state;
  logic [3:0]  r_own;
  logic [3:0]  r_ptr;
  logic [7:0]  r_cnt;

  state_t      w_state_nxt;
  logic [3:0]  w_own_nxt;
  logic [3:0]  w_ptr_nxt;
  logic [7:0]  w_cnt_nxt;

  logic [15:0] w_own_oh;
  logic [15:0] w_others;
  logic [3:0]  w_own_p1;
  logic        w_own_req;
  logic        w_any_req;
  logic        w_any_oth;
  logic        w_expired;

  // First set bit of m, searching upward from s with wrap.
  function automatic logic [3:0] pick(
    input logic [15:0] m,
    input logic [3:0]  s
  );
    logic [3:0] r;
    logic [3:0] j;
    logic       f;
    r = s;
    f = 1'b0;
    for (int i = 0; i < 16; i++) begin
      j = s + 4'(i);
      if (!f && m[j]) begin
        r = j;
        f = 1'b1;
      end
    end
    return r;
  endfunction

  // Owner-derived terms shared by release and preempt paths.
  always_comb begin
    w_own_oh  = 16'h0001 << r_own;
    w_others  = bus.req & ~w_own_oh;
    w_own_p1  = r_own + 4'd1;
    w_own_req = bus.req[r_own];
    w_any_req = |bus.req;
    w_any_oth = |w_others;
    w_expired = (r_cnt >= LP_MAX);
  end

  // Next-state: acquire from idle, release/handoff, preempt, hold.
  always_comb begin
    w_state_nxt = r_state;
    w_own_nxt   = r_own;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 8'd0;
        if (w_any_req) begin
          w_state_nxt = S_OWNED;
          w_own_nxt   = pick(bus.req, r_ptr);
          w_cnt_nxt   = 8'd1;
        end
      end
      S_OWNED: begin
        if (!w_own_req) begin
          w_ptr_nxt = w_own_p1;
          if (w_any_oth) begin
            w_own_nxt = pick(w_others, w_own_p1);
            w_cnt_nxt = 8'd1;
          end else begin
            w_state_nxt = S_IDLE;
            w_own_nxt   = 4'd0;
            w_cnt_nxt   = 8'd0;
          end
        end else if (w_expired && w_any_oth) begin
          w_own_nxt = pick(w_others, w_own_p1);
          w_ptr_nxt = w_own_p1;
          w_cnt_nxt = 8'd1;
        end else if (r_cnt < LP_MAX) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State registers; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_own   <= 4'd0;
      r_ptr   <= 4'd0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_own   <= w_own_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs are a pure decode of the registered owner.
  always_comb begin
    bus.grant       = 16'h0000;
    bus.grant_idx   = 4'd0;
    bus.grant_valid = 1'b0;
    bus.hold_cnt    = r_cnt;
    if (r_state == S_OWNED) begin
      bus.grant       = w_own_oh;
      bus.grant_idx   = r_own;
      bus.grant_valid = 1'b1;
    end
  end

endmodule

// File: doc/rr_arbiter16.md
# rr_arbiter16

Registered 16-way round-robin arbiter that shares a single decoded resource (one-hot select bus driven from a 4-bit index) among 16 requesters. It produces a one-hot grant vector plus its 4-bit encoded index, so downstream logic can use either the one-hot select or the index that feeds a 4-to-16 select decoder. Ownership lasts until the owner drops its request or a hold-time limit expires while others wait. It sits between requesting agents and the shared datapath select.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive granted cycles before preemption; legal range 1..255.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 16: request vector; bit i is requester i; level-sensitive.
- `grant` output 16: one-hot grant, or all zero; registered.
- `grant_idx` output 4: binary index of the granted bit; 0 when idle.
- `grant_valid` output 1: high iff `grant` is nonzero.
- `hold_cnt` output 8: cycles the current owner has held the grant, saturating at `MAX_HOLD`.

## Operation
- State: FSM {IDLE, OWNED}, owner index `own[3:0]`, rotate pointer `ptr[3:0]`, counter `hold_cnt[7:0]`.
- Arbitration function `pick(mask, start)`: the first set bit of `mask` searching `start`, `start+1`, … modulo 16, wrapping 15→0.
- IDLE:
  - If `req` is zero, stay in IDLE.
  - Else set `own = pick(req, ptr)`, go to OWNED, set `hold_cnt = 1`.
- OWNED:
  - Release: if `req[own]` is sampled 0:
    - set `ptr = own+1` (mod 16);
    - if other requests are set, hand off directly: `own = pick(req, own+1)`, `hold_cnt = 1`, stay in OWNED, no idle bubble;
    - else go to IDLE.
  - Preempt: if `req[own]` is 1, `hold_cnt >= MAX_HOLD`, and `req & ~(1<<own)` is nonzero:
    - set `own = pick(req & ~(1<<own), own+1)`;
    - set `ptr = old own+1`, `hold_cnt = 1`.
  - Otherwise keep the owner. `hold_cnt` increments, saturating at `MAX_HOLD`. A saturated lone owner keeps the grant indefinitely.
- Outputs are a pure decode of registers:
  - `grant = (state==OWNED) ? (1<<own) : 0`;
  - `grant_idx = (state==OWNED) ? own : 0`;
  - `grant_valid = (state==OWNED)`.
- Exactly one or zero grant bits are set in every cycle, including the cycle after reset.
- Preempted requesters keep requesting. They regain the grant by normal rotation.

## Timing
- Reset: on any edge with `rst=1`:
  - state=IDLE, `ptr=0`, `own=0`, `hold_cnt=0`;
  - all outputs 0 the following cycle;
  - `rst` overrides all other activity, including mid-ownership; the grant drops in the next cycle.
- Latency: `req` sampled at edge k produces `grant` valid after edge k (1 cycle). A requester asserting and deasserting between edges is never seen.
- Release: owner drops `req` before edge k; its grant is low after edge k. The new owner's grant is high after the same edge k.
- Preempt: with `MAX_HOLD=M`, the owner is granted for exactly M cycles when contention exists from its first cycle on. The next owner's grant appears in cycle M+1.
- Simultaneous release and timeout: the release rule applies; both yield the same next owner.
- `MAX_HOLD=1`: the grant rotates every cycle under contention.
- Wrap: owner 15 releases with `req[0]` pending gives next owner 0, `ptr=0`.

## Test plan
- Reset/idle:
  - Hold `rst=1` for 3 cycles with `req=16'hFFFF`: `grant=0`, `grant_idx=0`, `grant_valid=0`, `hold_cnt=0` throughout.
  - Release reset with `req=16'h0000`: outputs remain 0.
- Single request latency:
  - After reset, drive `req=16'h0020` at edge k: `grant=16'h0020`, `grant_idx=5`, `hold_cnt=1` after k.
  - Hold 20 cycles: the grant is stable and `hold_cnt` saturates at 16.
- Rotation and handoff:
  - Drive `req=16'h8001`. Requester 0 wins first.
  - Drop `req[0]` for one cycle: grant moves to 15 in the same edge, with no cycle of `grant_valid=0`.
  - Requester 15 releases with `req[0]` asserted: grant wraps to 0.
- Preemption with `MAX_HOLD=4`:
  - Drive `req=16'h0006` held constant: grant sequence is 1,1,1,1,2,2,2,2,1,… (`grant_idx`).
  - `hold_cnt` counts 1..4 in each tenure.
- Reset mid-ownership:
  - While requester 9 is granted with `hold_cnt=3`, pulse `rst` for 1 cycle: outputs go to 0 the next cycle.
  - Then, with `req=16'h0300`, requester 8 is granted (`ptr` reset to 0).
- Invariant check: under 10k cycles of random `req`, verify:
  - `grant` is one-hot or zero;
  - `grant == (1<<grant_idx)` when `grant_valid` is high;
  - no requester waits more than 15×`MAX_HOLD`+15 cycles while continuously requesting.
